// File: rtl/n64_vi_pattern_gen.sv
// N64 VI bus transmitter: drives nDSYNC and the multiplexed sync/R/G/B data bus
// from built-in test patterns, with optional emulation of the console's odd-pixel blur.
module n64_vi_pattern_gen #(
  parameter int COLOR_W     = 7,
  parameter int H_TOTAL     = 773,
  parameter int H_SYNC_LEN  = 57,
  parameter int CLAMP_LEN   = 16,
  parameter int H_ACT_START = 120,
  parameter int H_ACT_LEN   = 640,
  parameter int V_TOTAL     = 263,
  parameter int V_SYNC_LEN  = 3,
  parameter int V_ACT_START = 20,
  parameter int V_ACT_LEN   = 240
) (
  input  logic               VCLK,
  input  logic               nRST,
  input  logic               enable,
  input  logic               interlace,
  input  logic               blur_en,
  input  logic [1:0]         pattern_sel,
  output logic               nDSYNC,
  output logic [COLOR_W-1:0] D_o,
  output logic               field_start
);

  localparam int XW = $clog2(H_TOTAL + 1);
  localparam int YW = $clog2(V_TOTAL + 1);
  localparam int CW = 3 * COLOR_W;

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] HS_END = XW'(H_SYNC_LEN);
  localparam logic [XW-1:0] CL_END = XW'(H_SYNC_LEN + CLAMP_LEN);
  localparam logic [XW-1:0] HA_BEG = XW'(H_ACT_START);
  localparam logic [XW-1:0] HA_END = XW'(H_ACT_START + H_ACT_LEN);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] VS_END = YW'(V_SYNC_LEN);
  localparam logic [YW-1:0] VA_BEG = YW'(V_ACT_START);
  localparam logic [YW-1:0] VA_END = YW'(V_ACT_START + V_ACT_LEN);
  localparam logic [15:0]   AX_LAST = 16'(H_ACT_LEN - 1);

  typedef enum logic [1:0] {PH_SYNC, PH_R, PH_G, PH_B} phase_t;

  phase_t          phase, phase_nxt;
  logic [XW-1:0]   x, x_nxt;
  logic [YW-1:0]   y, y_nxt;
  logic            field, field_nxt;
  logic            s_en, s_en_nxt, s_il, s_il_nxt, s_blur, s_blur_nxt;
  logic [1:0]      s_pat, s_pat_nxt;
  logic [CW-1:0]   behind, behind_nxt, ahead, ahead_nxt;
  logic            nds_nxt, fs_nxt;
  logic [COLOR_W-1:0] d_nxt;

  logic            is_fs, run, il, blur;
  logic [1:0]      sel;
  logic            nh, nv, nc, ncl, act, ay0;
  logic [15:0]     ax;
  logic [YW-1:0]   y_last;
  logic [CW-1:0]   rgb;
  logic [COLOR_W-1:0] cur_c, bh_c, ah_c, comp;
  logic [COLOR_W:0]   sum;

  function automatic logic [CW-1:0] pat(input logic [1:0] psel, input logic [7:0] pax,
                                        input logic pay0);
    logic [COLOR_W-1:0] r, g, b;
    r = '0;
    g = '0;
    b = '0;
    case (psel)
      2'b00: begin
        r = {1'b1, {(COLOR_W-1){1'b0}}};
        g = r;
        b = r;
      end
      2'b01: begin
        r = pax[7] ? '1 : '0;
        g = pax[6] ? '1 : '0;
        b = pax[5] ? '1 : '0;
      end
      2'b10: begin
        r = COLOR_W'(pax);
        g = r;
        b = r;
      end
      default: begin
        r = (pax[0] ^ pay0) ? '1 : '0;
        g = r;
        b = r;
      end
    endcase
    return {r, g, b};
  endfunction

  always_comb begin
    is_fs = (phase == PH_SYNC) && (x == '0) && (y == '0);
    run   = is_fs ? enable      : s_en;
    il    = is_fs ? interlace   : s_il;
    blur  = is_fs ? blur_en     : s_blur;
    sel   = is_fs ? pattern_sel : s_pat;

    nh  = (x >= HS_END);
    nv  = (y >= VS_END);
    nc  = nv ? nh : ~nh;
    ncl = ~(nv && (x >= HS_END) && (x < CL_END));
    act = (x >= HA_BEG) && (x < HA_END) && (y >= VA_BEG) && (y < VA_END);
    ax  = 16'(x) - 16'(H_ACT_START);
    ay0 = y[0] ^ VA_BEG[0];
    rgb = pat(sel, ax[7:0], ay0);

    cur_c = rgb[COLOR_W-1:0];
    bh_c  = behind[COLOR_W-1:0];
    ah_c  = ahead[COLOR_W-1:0];
    case (phase)
      PH_R: begin
        cur_c = rgb[CW-1 -: COLOR_W];
        bh_c  = behind[CW-1 -: COLOR_W];
        ah_c  = ahead[CW-1 -: COLOR_W];
      end
      PH_G: begin
        cur_c = rgb[2*COLOR_W-1 -: COLOR_W];
        bh_c  = behind[2*COLOR_W-1 -: COLOR_W];
        ah_c  = ahead[2*COLOR_W-1 -: COLOR_W];
      end
      default: ;
    endcase
    sum  = {1'b0, bh_c} + {1'b0, ah_c};
    comp = cur_c;
    if (blur && ax[0])
      comp = (ax == AX_LAST) ? bh_c : sum[COLOR_W:1];

    y_last = il ? (Y_LAST - YW'(field)) : Y_LAST;

    phase_nxt  = phase;
    x_nxt      = x;
    y_nxt      = y;
    field_nxt  = field;
    behind_nxt = behind;
    ahead_nxt  = ahead;
    s_en_nxt   = is_fs ? enable      : s_en;
    s_il_nxt   = is_fs ? interlace   : s_il;
    s_blur_nxt = is_fs ? blur_en     : s_blur;
    s_pat_nxt  = is_fs ? pattern_sel : s_pat;
    nds_nxt    = 1'b1;
    d_nxt      = '0;
    fs_nxt     = 1'b0;

    if (!run) begin
      phase_nxt = PH_SYNC;
      x_nxt     = '0;
      y_nxt     = '0;
      field_nxt = 1'b0;
    end else begin
      fs_nxt = is_fs;
      if (phase == PH_SYNC) begin
        nds_nxt    = 1'b0;
        d_nxt[3:0] = {nv, ncl, nh, nc};
      end else if (act) begin
        d_nxt = comp;
      end
      case (phase)
        PH_SYNC: phase_nxt = PH_R;
        PH_R:    phase_nxt = PH_G;
        PH_G:    phase_nxt = PH_B;
        default: begin
          phase_nxt = PH_SYNC;
          // Neighbours for the next pixel: c(ax) becomes its left, c(ax+2) its right.
          behind_nxt = rgb;
          ahead_nxt  = pat(sel, ax[7:0] + 8'd2, ay0);
          if (x == X_LAST) begin
            x_nxt = '0;
            if (y == y_last) begin
              y_nxt     = '0;
              field_nxt = il & ~field;
            end else begin
              y_nxt = y + 1'b1;
            end
          end else begin
            x_nxt = x + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      phase       <= PH_SYNC;
      x           <= '0;
      y           <= '0;
      field       <= 1'b0;
      s_en        <= 1'b0;
      s_il        <= 1'b0;
      s_blur      <= 1'b0;
      s_pat       <= '0;
      behind      <= '0;
      ahead       <= '0;
      nDSYNC      <= 1'b1;
      D_o         <= '0;
      field_start <= 1'b0;
    end else begin
      phase       <= phase_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      field       <= field_nxt;
      s_en        <= s_en_nxt;
      s_il        <= s_il_nxt;
      s_blur      <= s_blur_nxt;
      s_pat       <= s_pat_nxt;
      behind      <= behind_nxt;
      ahead       <= ahead_nxt;
      nDSYNC      <= nds_nxt;
      D_o         <= d_nxt;
      field_start <= fs_nxt;
    end
  end

endmodule

// File: tb/tb_n64_vi_pattern_gen.sv
// Directed bench for n64_vi_pattern_gen on a reduced raster (50x7 lines, 40x3 active)
// so whole fields fit in a short run; word offsets are counted from each field_start.
module tb_n64_vi_pattern_gen;

  localparam int W  = 7;
  localparam int HT = 50;

  logic         VCLK = 1'b0;
  logic         nRST = 1'b0;
  logic         enable = 1'b0;
  logic         interlace = 1'b0;
  logic         blur_en = 1'b0;
  logic [1:0]   pattern_sel = 2'b00;
  logic         nDSYNC;
  logic [W-1:0] D_o;
  logic         field_start;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fs_cyc = 0;
  int prev = 0;

  always #5 VCLK = ~VCLK;
  always @(posedge VCLK) cyc <= cyc + 1;

  n64_vi_pattern_gen #(
    .COLOR_W(W), .H_TOTAL(HT), .H_SYNC_LEN(3), .CLAMP_LEN(2),
    .H_ACT_START(6), .H_ACT_LEN(40), .V_TOTAL(7), .V_SYNC_LEN(1),
    .V_ACT_START(2), .V_ACT_LEN(3)
  ) dut (
    .VCLK(VCLK), .nRST(nRST), .enable(enable), .interlace(interlace),
    .blur_en(blur_en), .pattern_sel(pattern_sel), .nDSYNC(nDSYNC),
    .D_o(D_o), .field_start(field_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fs(input int limit);
    bit got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge VCLK);
      if (field_start === 1'b1) begin
        got = 1'b1;
        fs_cyc = cyc;
      end
    end
    chk("fs_seen", {31'b0, got}, 32'd1);
  endtask

  task automatic at(input int off);
    while (cyc < fs_cyc + off) @(negedge VCLK);
  endtask

  task automatic word(input string tag, input int off, input logic ds, input logic [W-1:0] d);
    at(off);
    chk({tag, "_ds"}, {31'b0, nDSYNC}, {31'b0, ds});
    chk({tag, "_d"}, {25'b0, D_o}, {25'b0, d});
  endtask

  initial begin
    repeat (5) @(negedge VCLK);
    chk("rst_ds", {31'b0, nDSYNC}, 32'd1);
    chk("rst_d", {25'b0, D_o}, 32'd0);
    chk("rst_fs", {31'b0, field_start}, 32'd0);

    // grey, progressive
    enable = 1'b1;
    nRST = 1'b1;
    prev = cyc;
    wait_fs(4);
    chk("first_fs_lat", fs_cyc - prev, 32'd1);
    word("fs_word", 0, 1'b0, 7'h05);
    word("x0_p1", 1, 1'b1, 7'h00);
    word("x3y0", 12, 1'b0, 7'h06);
    word("x0y1", 200, 1'b0, 7'h0C);
    word("x3y1", 212, 1'b0, 7'h0B);
    word("x5y1", 220, 1'b0, 7'h0F);
    word("grey_g", 426, 1'b1, 7'h40);
    word("grey_y5", (5 * HT + 11) * 4 + 1, 1'b1, 7'h00);
    prev = fs_cyc;
    wait_fs(2000);
    chk("period_prog", fs_cyc - prev, 32'd1400);

    // interlace: 7-line and 6-line fields alternate
    interlace = 1'b1;
    wait_fs(2000);
    prev = fs_cyc;
    wait_fs(2000);
    chk("period_il_f0", fs_cyc - prev, 32'd1400);
    prev = fs_cyc;
    wait_fs(2000);
    chk("period_il_f1", fs_cyc - prev, 32'd1200);
    prev = fs_cyc;
    wait_fs(2000);
    chk("period_il_f0b", fs_cyc - prev, 32'd1400);
    interlace = 1'b0;

    // ramp
    pattern_sel = 2'b10;
    blur_en = 1'b0;
    wait_fs(2000);
    word("ramp5", 445, 1'b1, 7'h05);
    word("ramp39", 581, 1'b1, 7'h27);
    word("ramp_inact", 585, 1'b1, 7'h00);
    blur_en = 1'b1;
    wait_fs(2000);
    word("ramp4_b", 441, 1'b1, 7'h04);
    word("ramp5_b_r", 445, 1'b1, 7'h05);
    word("ramp5_b_b", 447, 1'b1, 7'h05);
    word("ramp39_b", 581, 1'b1, 7'h26);

    // colour bars
    pattern_sel = 2'b01;
    wait_fs(2000);
    word("bar30_b", 547, 1'b1, 7'h00);
    word("bar31_r", 549, 1'b1, 7'h00);
    word("bar31_b", 551, 1'b1, 7'h3F);
    word("bar32_b", 555, 1'b1, 7'h7F);
    blur_en = 1'b0;
    wait_fs(2000);
    word("bar31_nb", 551, 1'b1, 7'h00);
    word("bar32_nb", 555, 1'b1, 7'h7F);

    // checker with blur
    pattern_sel = 2'b11;
    blur_en = 1'b1;
    wait_fs(2000);
    word("chk_ay0_ax0", 425, 1'b1, 7'h00);
    word("chk_ay0_ax1", 429, 1'b1, 7'h00);
    word("chk_ay0_last", 581, 1'b1, 7'h00);
    word("chk_ay1_ax0", 625, 1'b1, 7'h7F);
    word("chk_ay1_ax1", 629, 1'b1, 7'h7F);
    word("chk_ay1_last", 781, 1'b1, 7'h7F);

    // enable dropped mid-field: field completes, then idle
    enable = 1'b0;
    word("dis_lastpix", 1396, 1'b0, 7'h0F);
    word("dis_idle0", 1400, 1'b1, 7'h00);
    chk("dis_fs", {31'b0, field_start}, 32'd0);
    word("dis_idle1", 1460, 1'b1, 7'h00);
    enable = 1'b1;
    prev = cyc;
    wait_fs(4);
    chk("reen_lat", fs_cyc - prev, 32'd1);
    word("reen_word", 0, 1'b0, 7'h05);

    // reset mid-line, just before a sync phase
    at(231);
    nRST = 1'b0;
    @(negedge VCLK);
    chk("rstm_ds", {31'b0, nDSYNC}, 32'd1);
    chk("rstm_d", {25'b0, D_o}, 32'd0);
    chk("rstm_fs", {31'b0, field_start}, 32'd0);
    @(negedge VCLK);
    nRST = 1'b1;
    prev = cyc;
    wait_fs(4);
    chk("rstm_fs_lat", fs_cyc - prev, 32'd1);
    word("rstm_word", 0, 1'b0, 7'h05);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
